// File: rtl/des_pkg.sv
// Shared DES tables, state and mode encodings for the DES engine.
// Tables hold FIPS 46-3 one-based bit positions, MSB-first.
package des_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2,
    2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2,
    2'd2, 2'd2, 2'd2, 2'd1
  };

  // right=0 rotates toward bit 0 (DES left shift)
  function automatic logic [0:27] rot28(
    input logic [0:27] x,
    input logic        right,
    input logic        two
  );
    logic [0:27] r;
    unique case ({right, two})
      2'b00:   r = {x[1:27], x[0]};
      2'b01:   r = {x[2:27], x[0:1]};
      2'b10:   r = {x[27], x[0:26]};
      default: r = {x[26:27], x[0:25]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_key_scheduler_if.sv
// Handshake bundle between round controller and key scheduler.
interface des_key_scheduler_if;
  logic        start_strobe_din;
  logic [0:63] key_din;
  logic        mode_din;
  logic        advance_din;
  logic [0:47] round_key_dout;
  logic        round_key_valid_dout;
  logic [3:0]  round_index_dout;
  logic        busy_dout;
  logic        done_dout;

  modport master (
    output start_strobe_din,
    output key_din,
    output mode_din,
    output advance_din,
    input  round_key_dout,
    input  round_key_valid_dout,
    input  round_index_dout,
    input  busy_dout,
    input  done_dout
  );

  modport slave (
    input  start_strobe_din,
    input  key_din,
    input  mode_din,
    input  advance_din,
    output round_key_dout,
    output round_key_valid_dout,
    output round_index_dout,
    output busy_dout,
    output done_dout
  );
endinterface

// File: rtl/des_pc2.sv
// DES PC-2 compression: 56-bit C||D to 48-bit subkey.
// Purely combinational; bit 0 is MSB on both sides.
module des_pc2
  import des_pkg::*;
(
  input  logic [0:55] cd_i,
  output logic [0:47] k_o
);

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign k_o[i] = cd_i[PC2[i]-1];
  end

  // positions PC-2 drops
  logic unused_bits;
  assign unused_bits = ^{cd_i[8], cd_i[17], cd_i[21],
                         cd_i[24], cd_i[34], cd_i[37],
                         cd_i[42], cd_i[53]};

endmodule

// File: rtl/des_key_scheduler.sv
// Iterative DES subkey generator, encrypt (K1..K16) or
// decrypt (K16..K1) order, one key per accepted advance.
module des_key_scheduler
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  des_key_scheduler_if.slave ks
);

  state_e      state_q;
  logic [0:27] c_q, d_q;
  logic [0:27] c_d, d_d;
  logic [0:27] c0, d0;
  logic [3:0]  cnt_q;
  logic        mode_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;
  logic [3:0]  sh_idx;
  logic        two;
  logic [0:47] pc2_k;

  for (genvar i = 0; i < 28; i++) begin : g_pc1
    assign c0[i] = ks.key_din[PC1[i]-1];
    assign d0[i] = ks.key_din[PC1[i+28]-1];
  end

  logic unused_parity;
  assign unused_parity = ^{ks.key_din[7], ks.key_din[15],
                           ks.key_din[23], ks.key_din[31],
                           ks.key_din[39], ks.key_din[47],
                           ks.key_din[55], ks.key_din[63]};

  // enc: step to K(n+2); dec: undo round 16-n
  always_comb begin
    sh_idx = (mode_q == MODE_DEC) ? ~cnt_q : cnt_q + 4'd1;
    two    = (SHIFTS[sh_idx] == 2'd2);
    c_d    = rot28(c_q, mode_q, two);
    d_d    = rot28(d_q, mode_q, two);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_ENC;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ks.start_strobe_din) begin
            state_q <= S_LOAD;
            mode_q  <= ks.mode_din;
            c_q     <= c0;
            d_q     <= d0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          state_q <= S_ROUND;
          valid_q <= 1'b1;
          // decrypt starts at K16 where C16/D16 equal C0/D0
          if (mode_q == MODE_ENC) begin
            c_q <= rot28(c_q, 1'b0, 1'b0);
            d_q <= rot28(d_q, 1'b0, 1'b0);
          end
        end
        S_ROUND: begin
          if (ks.advance_din) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              c_q <= c_d;
              d_q <= d_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd_i ({c_q, d_q}),
    .k_o  (pc2_k)
  );

  assign ks.round_key_dout       = valid_q ? pc2_k : '0;
  assign ks.round_key_valid_dout = valid_q;
  assign ks.round_index_dout     = cnt_q;
  assign ks.busy_dout            = busy_q;
  assign ks.done_dout            = done_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Scoreboard bench for des_key_scheduler against a
// direct FIPS 46-3 subkey model (cumulative shifts).
module tb_des_key_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  des_key_scheduler_if ks();

  des_key_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .ks    (ks)
  );

  localparam int M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int M_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2,
                               1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

  typedef struct {
    logic [47:0] k;
    int          idx;
  } exp_t;

  exp_t exp_q[$];

  // Round r subkey straight from C0/D0 and total shift count
  function automatic logic [47:0] subkey(input logic [63:0] key,
                                         input int r);
    bit cd [56];
    bit cr [28];
    bit dr [28];
    int s;
    int p;
    logic [47:0] k;
    s = 0;
    for (int i = 0; i < r; i++) s += M_SH[i];
    for (int i = 0; i < 56; i++) cd[i] = key[64 - M_PC1[i]];
    for (int j = 0; j < 28; j++) begin
      cr[j] = cd[(j + s) % 28];
      dr[j] = cd[28 + (j + s) % 28];
    end
    k = '0;
    for (int i = 0; i < 48; i++) begin
      p = M_PC2[i] - 1;
      k = {k[46:0], (p < 28) ? cr[p] : dr[p - 28]};
    end
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every key consumed by the round controller
  always @(negedge clk) begin
    if (ks.round_key_valid_dout === 1'b1 && ks.advance_din === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: got key %h idx %0d required none",
                 ks.round_key_dout, ks.round_index_dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ks.round_key_dout !== e.k ||
            ks.round_index_dout !== 4'(e.idx)) begin
          failures++;
          $display("FAIL sb_key: got %h idx %0d required %h idx %0d",
                   ks.round_key_dout, ks.round_index_dout, e.k, e.idx);
        end
      end
    end
    if (ks.done_dout === 1'b1) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL sb_done: got %0d keys pending required 0",
                 exp_q.size());
      end
    end
  end

  task automatic run(input logic [63:0] key, input logic mode,
                     input int stall_at, input int ign_at,
                     input int rst_at, input bit rnd_adv,
                     input bit chk_k, input logic [47:0] k0,
                     input logic [47:0] k15);
    int given;
    int guard;
    int first;
    bit stalled;
    bit adv;
    logic [47:0] sk;
    logic [3:0] si;
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.k   = subkey(key, mode ? 16 - i : i + 1);
      e.idx = i;
      exp_q.push_back(e);
    end
    ks.start_strobe_din = 1'b1;
    ks.key_din          = key;
    ks.mode_din         = mode;
    tick();
    ks.start_strobe_din = 1'b0;
    ks.key_din          = {$urandom, $urandom};
    ks.mode_din         = 1'($urandom);
    chk("load_busy", 64'(ks.busy_dout), 64'd1);
    tick();
    chk("first_valid", 64'(ks.round_key_valid_dout), 64'd1);
    if (chk_k) chk("k_idx0", 64'(ks.round_key_dout), 64'(k0));
    first   = cyc;
    given   = 0;
    guard   = 0;
    stalled = 1'b0;
    while (given < 16 && guard < 400) begin
      guard++;
      adv = rnd_adv ? 1'($urandom) : 1'b1;
      if (given == rst_at) begin
        ks.advance_din = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_outputs",
            64'({ks.round_key_dout, ks.round_key_valid_dout,
                 ks.round_index_dout, ks.busy_dout, ks.done_dout}),
            64'd0);
        exp_q.delete();
        return;
      end
      if (given == stall_at && !stalled) begin
        stalled = 1'b1;
        ks.advance_din = 1'b0;
        sk = ks.round_key_dout;
        si = ks.round_index_dout;
        repeat (5) begin
          tick();
          chk("stall_hold",
              64'({ks.round_key_dout, ks.round_index_dout,
                   ks.round_key_valid_dout}),
              64'({sk, si, 1'b1}));
        end
      end
      if (chk_k && given == 15 && adv)
        chk("k_idx15", 64'(ks.round_key_dout), 64'(k15));
      if (given == ign_at) begin
        ks.start_strobe_din = 1'b1;
        ks.key_din          = {$urandom, $urandom};
        ks.mode_din         = ~mode;
      end
      ks.advance_din = adv;
      tick();
      ks.start_strobe_din = 1'b0;
      if (adv) given++;
    end
    ks.advance_din = 1'b0;
    if (given < 16) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d keys required 16", given);
    end
    chk("done_state",
        64'({ks.done_dout, ks.round_key_valid_dout, ks.busy_dout,
             ks.round_key_dout}),
        64'({1'b1, 1'b0, 1'b1, 48'h0}));
    if (!rnd_adv && stall_at < 0)
      chk("done_latency", 64'(cyc - first), 64'd16);
    tick();
    chk("back_idle",
        64'({ks.done_dout, ks.busy_dout, ks.round_key_valid_dout}),
        64'd0);
  endtask

  initial begin
    reset               = 1'b1;
    ks.start_strobe_din = 1'b0;
    ks.key_din          = '0;
    ks.mode_din         = 1'b0;
    ks.advance_din      = 1'b0;
    repeat (2) tick();
    chk("reset_outputs",
        64'({ks.round_key_dout, ks.round_key_valid_dout,
             ks.round_index_dout, ks.busy_dout, ks.done_dout}),
        64'd0);
    reset = 1'b0;
    tick();

    ks.advance_din = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_advance",
          64'({ks.round_key_valid_dout, ks.busy_dout,
               ks.round_index_dout}),
          64'd0);
    end
    ks.advance_din = 1'b0;

    run(KEY_A, 1'b0, -1, -1, -1, 1'b0, 1'b1, K1_A, K16_A);
    run(KEY_A, 1'b1, -1, -1, -1, 1'b0, 1'b1, K16_A, K1_A);
    run(KEY_A, 1'b0, 7, -1, -1, 1'b0, 1'b1, K1_A, K16_A);
    run(KEY_A, 1'b1, -1, 4, -1, 1'b0, 1'b1, K16_A, K1_A);
    run(KEY_A, 1'b0, -1, -1, 9, 1'b0, 1'b0, '0, '0);
    tick();
    run(KEY_A, 1'b0, -1, -1, -1, 1'b0, 1'b1, K1_A, K16_A);
    run(64'h0, 1'b0, -1, -1, -1, 1'b0, 1'b1, 48'h0, 48'h0);

    for (int n = 0; n < 6; n++) begin
      run({$urandom, $urandom}, 1'($urandom), $urandom_range(0, 15),
          $urandom_range(0, 15), -1, 1'b1, 1'b0, '0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
